// File: rtl/icache_sa_pkg.sv
// Shared types and constants for the set-associative instruction cache.
package icache_sa_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 32;

   typedef enum logic [2:0] {
      StIdle,
      StLookup,
      StFill,
      StResp,
      StFlush
   } cache_state_e;

   // Bit width needed to index n items, never less than one bit.
   function automatic int unsigned idx_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icache_way_ram.sv
// One cache way: tag array and data array with synchronous read and a single write port.
module icache_way_ram
   import icache_sa_pkg::*;
#(
   parameter int unsigned IDX_W = 8,
   parameter int unsigned OFF_W = 2,
   parameter int unsigned TAG_W = 20
) (
   input  logic              clk,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [OFF_W-1:0]  rd_off,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [WORD_W-1:0] rd_data,
   input  logic              we,
   input  logic              tag_we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [OFF_W-1:0]  wr_off,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [TAG_W-1:0]  wr_tag
);

   localparam int unsigned SETS  = 1 << IDX_W;
   localparam int unsigned WORDS = SETS << OFF_W;

   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [WORD_W-1:0] data_mem [WORDS];

   // Write port: data beats during a fill, tag once the line is complete.
   always_ff @(posedge clk) begin
      if (tag_we) begin
         tag_mem[wr_idx] <= wr_tag;
      end
      if (we) begin
         data_mem[{wr_idx, wr_off}] <= wr_data;
      end
   end

   // Read port: outputs hold until the next accepted request.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_tag  <= tag_mem[rd_idx];
         rd_data <= data_mem[{rd_idx, rd_off}];
      end
   end

endmodule

// File: rtl/icache_sa.sv
// Set-associative read-only instruction cache with line fill, round-robin victim choice,
// whole-cache invalidate and hit/miss counters.
module icache_sa
   import icache_sa_pkg::*;
#(
   parameter int unsigned WAYS       = 4,
   parameter int unsigned SETS       = 256,
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [WORD_W-1:0] rsp_data,
   input  logic              inval,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int unsigned OFF_W = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W - 2;
   localparam int unsigned WAY_W = idx_bits(WAYS);

   cache_state_e state_q, state_d;

   // Request fields
   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;
   logic [OFF_W-1:0] req_off;
   logic [1:0]       unused_byte_off;

   assign req_tag         = req_addr[ADDR_W-1 -: TAG_W];
   assign req_idx         = req_addr[IDX_W+OFF_W+1 : OFF_W+2];
   assign req_off         = req_addr[OFF_W+1 : 2];
   assign unused_byte_off = req_addr[1:0];

   // Latched request and fill bookkeeping
   logic [TAG_W-1:0]  tag_q;
   logic [IDX_W-1:0]  idx_q;
   logic [OFF_W-1:0]  off_q;
   logic [OFF_W-1:0]  beat_q;
   logic              fill_done_q;
   logic [WAY_W-1:0]  victim_q;
   logic [WORD_W-1:0] word_q;
   logic              inval_q;

   // Per-set state kept in flops so a flush clears everything in one cycle
   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAY_W-1:0]  rr_q    [SETS];

   logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

   // Way RAM outputs
   logic [TAG_W-1:0]  way_tag  [WAYS];
   logic [WORD_W-1:0] way_data [WAYS];

   // Control strobes
   logic              accept;
   logic              lookup_hit;
   logic              lookup_miss;
   logic              fill_beat;
   logic              tag_wr;
   logic              flush;

   logic [WAYS-1:0]   hit_vec;
   logic [WORD_W-1:0] hit_data;
   logic [WAY_W-1:0]  victim;
   logic              victim_found;
   logic              use_rr;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_way_ram #(
         .IDX_W (IDX_W),
         .OFF_W (OFF_W),
         .TAG_W (TAG_W)
      ) u_way_ram (
         .clk     (clk),
         .rd_en   (accept),
         .rd_idx  (req_idx),
         .rd_off  (req_off),
         .rd_tag  (way_tag[w]),
         .rd_data (way_data[w]),
         .we      (fill_beat && (victim_q == WAY_W'(w))),
         .tag_we  (tag_wr && (victim_q == WAY_W'(w))),
         .wr_idx  (idx_q),
         .wr_off  (beat_q),
         .wr_data (mem_rdata),
         .wr_tag  (tag_q)
      );
   end

   // Tag compare across all ways; at most one way can match.
   always_comb begin
      hit_vec  = '0;
      hit_data = '0;
      for (int w = 0; w < WAYS; w++) begin
         hit_vec[w] = valid_q[idx_q][w] && (way_tag[w] == tag_q);
         if (hit_vec[w]) begin
            hit_data = hit_data | way_data[w];
         end
      end
   end

   // Victim choice: lowest invalid way, otherwise the set's round-robin pointer.
   always_comb begin
      victim       = rr_q[idx_q];
      victim_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!victim_found && !valid_q[idx_q][w]) begin
            victim       = WAY_W'(w);
            victim_found = 1'b1;
         end
      end
      use_rr = ~victim_found;
   end

   // Next-state and output decode.
   always_comb begin
      state_d     = state_q;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_data    = '0;
      mem_en      = 1'b0;
      accept      = 1'b0;
      lookup_hit  = 1'b0;
      lookup_miss = 1'b0;
      fill_beat   = 1'b0;
      tag_wr      = 1'b0;
      flush       = 1'b0;
      unique case (state_q)
         StIdle: begin
            // inval wins over a simultaneous request
            if (inval) begin
               state_d = StFlush;
            end else begin
               req_ready = 1'b1;
               if (req_valid) begin
                  accept  = 1'b1;
                  state_d = StLookup;
               end
            end
         end
         StLookup: begin
            if (|hit_vec) begin
               lookup_hit = 1'b1;
               rsp_valid  = 1'b1;
               rsp_data   = hit_data;
               if (inval_q || inval) begin
                  state_d = StFlush;
               end else begin
                  req_ready = 1'b1;
                  if (req_valid) begin
                     accept  = 1'b1;
                     state_d = StLookup;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end else begin
               lookup_miss = 1'b1;
               state_d     = StFill;
            end
         end
         StFill: begin
            if (!fill_done_q) begin
               mem_en = 1'b1;
               if (mem_ack) begin
                  fill_beat = 1'b1;
               end
            end else begin
               // All beats in: commit tag and valid before responding
               tag_wr  = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            rsp_valid = 1'b1;
            rsp_data  = word_q;
            state_d   = (inval_q || inval) ? StFlush : StIdle;
         end
         StFlush: begin
            flush   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign mem_addr = mem_en ? {tag_q, idx_q, beat_q, 2'b00} : '0;
   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the accepted request for compare and fill.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_q <= '0;
         idx_q <= '0;
         off_q <= '0;
      end else if (accept) begin
         tag_q <= req_tag;
         idx_q <= req_idx;
         off_q <= req_off;
      end
   end

   // Fill sequencing: beat counter, completion flag and requested-word capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         victim_q    <= '0;
         beat_q      <= '0;
         fill_done_q <= 1'b0;
         word_q      <= '0;
      end else if (lookup_miss) begin
         victim_q    <= victim;
         beat_q      <= '0;
         fill_done_q <= 1'b0;
      end else if (fill_beat) begin
         beat_q <= beat_q + OFF_W'(1);
         if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
            fill_done_q <= 1'b1;
         end
         if (beat_q == off_q) begin
            word_q <= mem_rdata;
         end
      end
   end

   // Remember an invalidate that arrives while a request is in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inval_q <= 1'b0;
      end else if (flush) begin
         inval_q <= 1'b0;
      end else if (inval && (state_q != StIdle) && (state_q != StFlush)) begin
         inval_q <= 1'b1;
      end
   end

   // Valid bits and round-robin pointers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else if (flush) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else begin
         if (tag_wr) begin
            valid_q[idx_q][victim_q] <= 1'b1;
         end
         // Pointer advances only when it actually picked the victim
         if (lookup_miss && use_rr) begin
            rr_q[idx_q] <= (rr_q[idx_q] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx_q] + WAY_W'(1);
         end
      end
   end

   // Hit and miss counters; wrap silently and survive invalidates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (lookup_hit) begin
            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
         end
         if (lookup_miss) begin
            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa against a set/way reference model.
module tb_icache_sa;

   localparam int unsigned WAYS       = 4;
   localparam int unsigned SETS       = 256;
   localparam int unsigned LINE_WORDS = 4;
   localparam int unsigned OFF_W      = 2;
   localparam int unsigned IDX_W      = 8;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        inval;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   icache_sa #(
      .WAYS       (WAYS),
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .ADDR_W     (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .inval     (inval),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: per set, a tag and valid flag per way plus a replacement pointer.
   bit          m_valid [SETS][WAYS];
   logic [31:0] m_tag   [SETS][WAYS];
   int          m_rr    [SETS];
   logic [31:0] m_hits;
   logic [31:0] m_misses;

   task automatic model_flush();
      for (int s = 0; s < SETS; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      end
   endtask

   task automatic model_reset();
      model_flush();
      m_hits   = '0;
      m_misses = '0;
   endtask

   task automatic model_access(input logic [31:0] a, output logic exp_hit);
      int          idx;
      int          vic;
      logic [31:0] tg;
      idx     = int'((a >> (2 + OFF_W)) % SETS);
      tg      = a >> (2 + OFF_W + IDX_W);
      exp_hit = 1'b0;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[idx][w] && m_tag[idx][w] == tg) exp_hit = 1'b1;
      if (exp_hit) begin
         m_hits++;
      end else begin
         m_misses++;
         vic = -1;
         for (int w = 0; w < WAYS; w++)
            if (vic < 0 && !m_valid[idx][w]) vic = w;
         if (vic < 0) begin
            vic       = m_rr[idx];
            m_rr[idx] = (m_rr[idx] + 1) % WAYS;
         end
         m_valid[idx][vic] = 1'b1;
         m_tag[idx][vic]   = tg;
      end
   endtask

   // Memory responder: data equals the word address; garbage when not acking.
   int          ack_mode;
   logic [31:0] beat_log [$];

   always @(negedge clk) begin
      if (ack_mode == 0) mem_ack = 1'b1;
      else               mem_ack = ($urandom_range(1) == 1);
      mem_rdata = mem_ack ? mem_addr : $urandom;
      if (mem_en && mem_ack) beat_log.push_back(mem_addr);
   end

   // One request; returns at the negedge where rsp_valid is seen.
   task automatic fetch(input logic [31:0] addr, output logic hit, output logic [31:0] data,
                        output int lat);
      int guard;
      hit  = 1'b0;
      data = '0;
      lat  = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = addr;
      guard     = 0;
      while (!req_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         check("req_ready_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid = 1'b0;
      while (!rsp_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) begin
         check("rsp_timeout", 32'd0, 32'd1);
         return;
      end
      hit  = (lat == 0);
      data = rsp_data;
   endtask

   task automatic do_access(input logic [31:0] addr, input string tag, output logic hit);
      logic        exp_hit;
      logic [31:0] data;
      int          lat;
      model_access(addr, exp_hit);
      fetch(addr, hit, data, lat);
      check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
      check({tag, "_data"}, data, addr & ~32'h3);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        h;
      logic [31:0] d;
      int          lat;
      int          base;
      int          guard;
      logic [31:0] a;

      rst       = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      inval     = 1'b0;
      ack_mode  = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_hit_cnt", hit_cnt, 32'd0);
      check("rst_miss_cnt", miss_cnt, 32'd0);
      rst = 1'b1;

      // Cold miss with an ack every cycle
      base = beat_log.size();
      model_access(32'h0000_1004, h);
      fetch(32'h0000_1004, h, d, lat);
      check("cold_hit", 32'(h), 32'd0);
      check("cold_data", d, 32'h0000_1004);
      check("cold_latency", 32'(lat), 32'(LINE_WORDS + 2));
      check("cold_beats", 32'(beat_log.size() - base), 32'd4);
      if (beat_log.size() >= base + 4)
         for (int i = 0; i < 4; i++)
            check("cold_beat_addr", beat_log[base+i], 32'h0000_1000 + 32'(4 * i));
      check("cold_miss_cnt", miss_cnt, m_misses);

      // Back-to-back hits on the filled line
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 32'h0000_1000;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check("stream_rsp_valid", 32'(rsp_valid), 32'd1);
         check("stream_data", rsp_data, 32'h0000_1000 + 32'(4 * (i - 1)));
         check("stream_mem_en", 32'(mem_en), 32'd0);
         model_access(32'h0000_1000 + 32'(4 * (i - 1)), h);
         if (i < 4) req_addr = 32'h0000_1000 + 32'(4 * i);
         else       req_valid = 1'b0;
      end
      @(negedge clk);
      check("stream_hit_cnt", hit_cnt, 32'd4);
      check("stream_miss_cnt", miss_cnt, m_misses);

      // Five tags into one set: the fifth evicts way 0
      for (int t = 0; t < 5; t++) begin
         do_access((32'(16 + t) << 12) | 32'h50, "repl_fill", h);
      end
      for (int t = 1; t < 4; t++) begin
         do_access((32'(16 + t) << 12) | 32'h54, "repl_keep", h);
         check("repl_keep_is_hit", 32'(h), 32'd1);
      end
      do_access(32'h0001_0058, "repl_evicted", h);
      check("repl_evicted_is_miss", 32'(h), 32'd0);

      // Invalidate raised mid-fill with gappy acks
      ack_mode = 1;
      fork
         do_access(32'h0000_3010, "infl", h);
         begin
            guard = 0;
            @(negedge clk);
            while (!mem_en && guard < 50) begin
               @(negedge clk);
               guard++;
            end
            inval = 1'b1;
            @(negedge clk);
            inval = 1'b0;
         end
      join
      @(negedge clk);
      check("infl_flush_ready", 32'(req_ready), 32'd0);
      model_flush();
      do_access(32'h0000_3010, "infl_after", h);
      check("infl_after_is_miss", 32'(h), 32'd0);
      do_access(32'h0000_3014, "infl_rehit", h);

      // Counter wrap
      @(negedge clk);
      force dut.hit_cnt_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.hit_cnt_q;
      m_hits = 32'hFFFF_FFFF;
      do_access(32'h0000_3018, "wrap", h);
      @(negedge clk);
      check("wrap_hit_cnt", hit_cnt, 32'd0);
      check("wrap_model_cnt", hit_cnt, m_hits);

      // Reset during the third fill beat
      ack_mode = 0;
      base     = beat_log.size();
      req_valid = 1'b1;
      req_addr  = 32'h0000_2008;
      @(negedge clk);
      req_valid = 1'b0;
      guard     = 0;
      #1;
      while (beat_log.size() < base + 3 && guard < 50) begin
         @(negedge clk);
         #1;
         guard++;
      end
      check("midfill_mem_en_before", 32'(mem_en), 32'd1);
      rst = 1'b0;
      #1;
      check("midfill_mem_en", 32'(mem_en), 32'd0);
      check("midfill_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midfill_mem_addr", mem_addr, 32'd0);
      check("midfill_miss_cnt", miss_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      do_access(32'h0000_1004, "post_rst", h);
      check("post_rst_is_miss", 32'(h), 32'd0);

      // Randomised traffic over a few sets and tags, with occasional idle invalidates
      for (int n = 0; n < 250; n++) begin
         ack_mode = int'($urandom_range(1));
         if ($urandom_range(15) == 0) begin
            @(negedge clk);
            inval = 1'b1;
            @(negedge clk);
            inval = 1'b0;
            check("rnd_flush_ready", 32'(req_ready), 32'd0);
            model_flush();
         end else begin
            a = (32'($urandom_range(6, 1)) << 12) | (32'($urandom_range(3)) << 4) |
                (32'($urandom_range(3)) << 2) | 32'($urandom_range(3));
            do_access(a, "rnd", h);
         end
      end
      @(negedge clk);
      check("final_hit_cnt", hit_cnt, m_hits);
      check("final_miss_cnt", miss_cnt, m_misses);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
